// File: rtl/shift_cmd_seq_if.sv
// Command bus from the controller into shift_cmd_seq: one valid/ready-qualified
// {load, data, dir, count} command per accepted beat; ready is registered.
interface shift_cmd_seq_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;

  modport master (
    output cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_count,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_data, cmd_dir, cmd_count,
    output cmd_ready
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// Queues load/shift commands and plays them onto a shift register's controls;
// first control 2 cycles after acceptance, cmd_ready drops (registered) while the FIFO is full.
module shift_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_cmd_seq_if.slave   cmd,
  output logic             en,
  output logic             left,
  output logic             right,
  output logic [WIDTH-1:0] load,
  output logic             busy,
  output logic             done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  typedef struct packed {
    logic             ld;
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] cnt;
  } ent_t;

  ent_t          mem [DEPTH];
  ent_t          ent_in;
  ent_t          head;
  ent_t          wk;
  ent_t          wk_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic [AW:0]   occ_nxt;
  logic [1:0]    state;
  logic [1:0]    nxt;
  logic          push;
  logic          pop;

  assign ent_in = '{ld: cmd.cmd_load, data: cmd.cmd_data, dir: cmd.cmd_dir, cnt: cmd.cmd_count};
  assign head   = mem[rd_ptr];
  assign push   = cmd.cmd_valid & cmd.cmd_ready;
  assign pop    = (state == IDLE) && (occ != '0);
  assign busy   = (state != IDLE) || (occ != '0);

  always_comb begin
    occ_nxt = occ;
    if (push && !pop)
      occ_nxt = occ + 1'b1;
    else if (pop && !push)
      occ_nxt = occ - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ent_in;
  end

  // The working register doubles as the shift down-counter once the command is popped.
  always_comb begin
    nxt    = state;
    wk_nxt = wk;
    case (state)
      IDLE: begin
        if (occ != '0) begin
          wk_nxt = head;
          if (head.ld)
            nxt = LOAD;
          else if (head.cnt != '0)
            nxt = SHIFT;
          else
            nxt = DONE;
        end
      end
      LOAD:    nxt = (wk.cnt != '0) ? SHIFT : DONE;
      SHIFT: begin
        if (wk.cnt == CNT_W'(1))
          nxt = DONE;
        else
          wk_nxt.cnt = wk.cnt - 1'b1;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      wk            <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occ           <= '0;
      cmd.cmd_ready <= 1'b1;
      en            <= 1'b0;
      left          <= 1'b0;
      right         <= 1'b0;
      load          <= '0;
      done          <= 1'b0;
    end else begin
      state         <= nxt;
      wk            <= wk_nxt;
      occ           <= occ_nxt;
      cmd.cmd_ready <= (occ_nxt != FULL_OCC);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // Controls are decoded from the next state so they line up with it cycle for cycle.
      en    <= (nxt == LOAD);
      left  <= (nxt == SHIFT) &&  wk_nxt.dir;
      right <= (nxt == SHIFT) && !wk_nxt.dir;
      done  <= (nxt == DONE);
      if (nxt == LOAD)
        load <= wk_nxt.data;
    end
  end

endmodule

// File: tb/tb_shift_cmd_seq.sv
// Directed bench for shift_cmd_seq: expected control events are queued at issue time
// and a negedge monitor pops and compares each event the DUT produces.
module tb_shift_cmd_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, left, right, busy, done;
  logic [3:0] load;

  shift_cmd_seq_if #(.WIDTH(4), .CNT_W(4)) cmd_if ();

  shift_cmd_seq #(.WIDTH(4), .CNT_W(4), .DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (cmd_if),
    .en    (en),
    .left  (left),
    .right (right),
    .load  (load),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       left;
    logic       right;
    logic [3:0] load;
    logic       done;
    logic       contig;
  } evt_t;

  evt_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_evt = -100;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: invariants every cycle, scoreboard pop on every control/done event.
  always @(negedge clk) begin
    evt_t e;
    chk("inv_left_right", {31'd0, left & right}, 32'd0);
    chk("inv_en_shift", {31'd0, en & (left | right)}, 32'd0);
    chk("inv_done_twice", {31'd0, done & prev_done}, 32'd0);
    prev_done <= done;
    if (en || left || right || done) begin
      if (sb.size() == 0) begin
        chk("unexpected_evt", {27'd0, en, left, right, done, 1'b1}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("evt_ctrl", {28'd0, en, left, right, done}, {28'd0, e.en, e.left, e.right, e.done});
        if (e.en) chk("evt_load", {28'd0, load}, {28'd0, e.load});
        if (e.contig) chk("evt_contig", cyc - last_evt, 32'd1);
        else          chk("evt_gap_ok", {31'd0, (cyc - last_evt) >= 2}, 32'd1);
      end
      last_evt = cyc;
    end
  end

  task automatic expect_cmd(input logic ld, input logic [3:0] d, input logic dr, input logic [3:0] c);
    evt_t e;
    if (ld) begin
      e = '{en: 1'b1, left: 1'b0, right: 1'b0, load: d, done: 1'b0, contig: 1'b0};
      sb.push_back(e);
    end
    for (int i = 0; i < int'(c); i++) begin
      e = '{en: 1'b0, left: dr, right: !dr, load: 4'd0, done: 1'b0, contig: (ld || i > 0)};
      sb.push_back(e);
    end
    e = '{en: 1'b0, left: 1'b0, right: 1'b0, load: 4'd0, done: 1'b1, contig: (ld || c != 0)};
    sb.push_back(e);
  endtask

  // Presents a command at a negedge; returns just after the accepting edge.
  task automatic push_cmd(input logic ld, input logic [3:0] d, input logic dr, input logic [3:0] c,
                          output int waited);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_load  = ld;
    cmd_if.cmd_data  = d;
    cmd_if.cmd_dir   = dr;
    cmd_if.cmd_count = c;
    waited = 0;
    while (!cmd_if.cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_if.cmd_ready) begin
      chk("push_timeout", 32'd0, 32'd1);
      cmd_if.cmd_valid = 1'b0;
    end else begin
      expect_cmd(ld, d, dr, c);
      @(posedge clk);
      #1 cmd_if.cmd_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    chk({nm, "_busy_clear"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1 chk({nm, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    int w;
    int n;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_load  = 1'b0;
    cmd_if.cmd_data  = 4'd0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_count = 4'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {27'd0, en, left, right, done, busy}, 32'd0);
    chk("rst_load", {28'd0, load}, 32'd0);
    chk("rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    rst = 1'b0;

    // Load then shift left 3, with latency check
    push_cmd(1'b1, 4'b1010, 1'b1, 4'd3, w);
    @(negedge clk);
    chk("lat_pop_cycle_en", {31'd0, en}, 32'd0);
    chk("lat_pop_cycle_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("lat_first_en", {31'd0, en}, 32'd1);
    chk("lat_first_load", {28'd0, load}, 32'hA);
    wait_idle("t1");
    chk("t1_load_held", {28'd0, load}, 32'hA);

    // Back-to-back: shift right 2, then load-only
    push_cmd(1'b0, 4'b0000, 1'b0, 4'd2, w);
    push_cmd(1'b1, 4'b0110, 1'b0, 4'd0, w);
    wait_idle("t2");

    // Fill FIFO behind a long command; 5th push must stall
    push_cmd(1'b0, 4'b0000, 1'b1, 4'd15, w);
    push_cmd(1'b1, 4'b0011, 1'b0, 4'd1, w);
    push_cmd(1'b0, 4'b0000, 1'b1, 4'd2, w);
    push_cmd(1'b0, 4'b0000, 1'b0, 4'd0, w);
    push_cmd(1'b1, 4'b1111, 1'b0, 4'd0, w);
    @(negedge clk);
    chk("full_ready_low", {31'd0, cmd_if.cmd_ready}, 32'd0);
    push_cmd(1'b0, 4'b0000, 1'b0, 4'd3, w);
    chk("fifth_push_stalled", {31'd0, w > 0}, 32'd1);
    wait_idle("t3");

    // Zero-length command
    push_cmd(1'b0, 4'b0000, 1'b1, 4'd0, w);
    wait_idle("t4");

    // Reset during the 2nd shift cycle with 2 commands queued
    push_cmd(1'b0, 4'b0000, 1'b1, 4'd5, w);
    push_cmd(1'b1, 4'b0101, 1'b0, 4'd2, w);
    push_cmd(1'b0, 4'b0000, 1'b0, 4'd1, w);
    n = 0;
    w = 0;
    while (n < 2 && w < 50) begin
      @(negedge clk);
      w++;
      if (left) n++;
    end
    chk("rst_wait_shift", n, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    chk("abort_ctrl", {27'd0, en, left, right, done, busy}, 32'd0);
    chk("abort_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
    repeat (30) @(negedge clk);
    chk("abort_busy_idle", {31'd0, busy}, 32'd0);
    chk("abort_no_evt", last_evt < cyc - 25, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shift_cmd_seq.md
Name: shift_cmd_seq

Overview:
- Command sequencer directly upstream of the bidirectional 4-bit shift register.
- Buffers load/shift commands from a controller through a valid/ready handshake.
- Drives the shift register's en, left, right and load inputs cycle by cycle, so the register never sees conflicting controls.
- Reports completion of each command with a done pulse.

Parameters:
WIDTH, 4, data width of the load word; matches the shift register width
CNT_W, 4, width of the shift-count field (maximum 2^CNT_W-1 shifts per command)
DEPTH, 4, command FIFO depth in entries (power of 2, at least 2)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command presented
cmd_ready  output  1  FIFO can accept a command
cmd_load  input  1  1 = load cmd_data before shifting
cmd_data  input  WIDTH  value to load
cmd_dir  input  1  0 = shift right, 1 = shift left
cmd_count  input  CNT_W  number of single-bit shifts
en  output  1  load strobe to the shift register
left  output  1  shift-left control
right  output  1  shift-right control
load  output  WIDTH  parallel load value
busy  output  1  a command is executing or the FIFO is non-empty
done  output  1  one-cycle pulse at the end of each command

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: en=0, left=0, right=0, load=0, done=0, busy=0, FIFO empty, FSM in IDLE, cmd_ready=1 in the cycle after reset.
- Reset mid-command:
  - Aborts the in-flight command and flushes the FIFO.
  - No done pulse is issued.
  - All controls are 0 from the next cycle.
- Handshake:
  - A command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1.
  - cmd_ready = !full and is registered.
  - When full, cmd_ready=0 even if a pop occurs in the same cycle (no bypass).
  - cmd_valid while cmd_ready=0 is ignored; the controller holds the command.
- FIFO: DEPTH entries of {cmd_load, cmd_data, cmd_dir, cmd_count}. Pointers wrap modulo DEPTH. Full and empty are tracked with an occupancy counter (0..DEPTH).
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: if the FIFO is non-empty, pop the head into working registers.
    - Next state is LOAD if cmd_load=1.
    - Otherwise next state is SHIFT if count>0.
    - Otherwise next state is DONE.
  - LOAD: exactly one cycle with en=1, load=data, left=right=0. Next state is SHIFT if count>0, else DONE.
  - SHIFT: drive left=dir and right=!dir for exactly count consecutive cycles, with en=0. A down-counter is loaded with count. Exit to DONE when the counter reaches 1 on the shift cycle.
  - DONE: done=1 for one cycle, all controls 0. Next state is IDLE.
- Outputs: all controls are registered; load holds its last value outside LOAD.
- Invariants:
  - left&right is never 1.
  - en&(left|right) is never 1.
- Latency:
  - A command accepted at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1.
  - Its first control (en or shift) is high in the cycle after edge t+1.
- Back-to-back commands: IDLE is visited for one cycle between commands. There is a minimum of 2 control-free cycles (DONE, IDLE) between commands.
- Zero-length command (cmd_load=0, count=0): no controls are asserted, done still pulses.
- busy = (state!=IDLE) | (count of FIFO entries != 0).

Test Plan:
- Reset, then push {load=1, data=1010, dir=1, count=3}:
  - en=1 with load=1010 for 1 cycle.
  - left=1 for exactly 3 cycles.
  - done pulses once, then busy=0.
- Push {load=0, dir=0, count=2} then {load=1, data=0110, count=0} back-to-back:
  - right=1 for 2 cycles, then done.
  - Then en=1 with load=0110, then done.
  - Exactly 2 done pulses.
- Fill the FIFO while a count=15 command runs (4 further pushes):
  - cmd_ready=0 after the 4th push.
  - A 5th push is ignored until a pop.
  - All 5 accepted commands execute in order.
- Zero-length command {load=0, count=0}: en, left and right stay 0; done pulses 1 cycle; busy returns to 0.
- Assert rst during the 2nd shift cycle of a count=5 command with 2 more queued:
  - Next cycle, all controls are 0, there is no done pulse and busy=0.
  - Queued commands never execute.
- Bench assertion on every cycle: !(left&right), !(en&(left|right)), and done is never high for 2 consecutive cycles.
